// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between the EXE stage and the multiply/divide sequencer.
// master = pipeline side, slave = muldiv_seq.
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier is zero.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic         clk,
    input  logic         clrn,
    muldiv_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_div0;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvs;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_b_zero;
    logic                 w_skip;
    logic [WIDTH:0]       w_part;
    logic [WIDTH:0]       w_sub;
    logic [WIDTH-1:0]     w_mplier_nxt;
    logic                 w_last;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    // NOTE: every combinational output gets a value on every path, so no latches are inferred.
    always_comb begin
        w_a_neg      = ~bus.op[0] & bus.a[WIDTH-1];
        w_b_neg      = ~bus.op[0] & bus.b[WIDTH-1];
        w_abs_a      = w_a_neg ? -bus.a : bus.a;
        w_abs_b      = w_b_neg ? -bus.b : bus.b;
        w_b_zero     = (bus.b == '0);

        // Partial remainder is always below the divisor, so bit WIDTH of the
        // WIDTH+1-bit difference is exactly the borrow of the trial subtract.
        w_part       = {r_rem, r_quo[WIDTH-1]};
        w_sub        = w_part - {1'b0, r_dvs};

        w_mplier_nxt = r_mplier >> 1;
        w_last       = (r_cnt == CNT_W'(WIDTH - 1));

        w_prod       = r_neg_q ? -r_acc : r_acc;
        w_quo        = r_neg_q ? -r_quo : r_quo;
        w_rem        = r_neg_r ? -r_rem : r_rem;
    end

`ifdef MULDIV_EARLY_OUT_EN
    assign w_mul_done = w_last | (w_mplier_nxt == '0);
    assign w_skip     = w_b_zero;
`else
    assign w_mul_done = w_last;
    assign w_skip     = w_b_zero & bus.op[1];
`endif

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wdata;
                    if (bus.lo_we) r_lo <= bus.wdata;
                    if (bus.start && !bus.cancel) begin
                        r_cnt    <= '0;
                        r_is_div <= bus.op[1];
                        r_div0   <= bus.op[1] & w_b_zero;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_rem    <= '0;
                        // A zero divisor never runs CALC, so r_quo carries the raw dividend into FIX.
                        r_quo    <= (bus.op[1] & w_b_zero) ? bus.a : w_abs_a;
                        r_dvs    <= w_abs_b;
                        r_busy   <= 1'b1;
                        r_state  <= w_skip ? FIX : CALC;
                    end
                end

                CALC: begin
                    if (bus.cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_is_div) begin
                            r_quo <= {r_quo[WIDTH-2:0], ~w_sub[WIDTH]};
                            r_rem <= w_sub[WIDTH] ? w_part[WIDTH-1:0] : w_sub[WIDTH-1:0];
                            if (w_last) r_state <= FIX;
                        end else begin
                            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                            r_mcand  <= r_mcand << 1;
                            r_mplier <= w_mplier_nxt;
                            if (w_mul_done) r_state <= FIX;
                        end
                    end
                end

                FIX: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    if (!bus.cancel) begin
                        r_done <= 1'b1;
                        if (r_div0) begin
                            r_hi <= r_quo;
                            r_lo <= '1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod[WIDTH-1:0];
                        end
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected HI/LO/latency, a monitor
// pops and compares on every done pulse.
module tb_muldiv_seq;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic clk;
    logic clrn;
    int   n_vec;
    int   n_err;
    int   busy_cnt;
    exp_t sb[$];

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int          n;
        if (op[1] && b == 32'd0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            m = (!op[0] && b[31]) ? -b : b;
            n = 0;
            while (m != 32'd0) begin
                m = m >> 1;
                n++;
            end
            return n + 1;
        end
`endif
        return 33;
    endfunction

    // Monitor: busy_cnt counts busy samples of the current operation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!clrn) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {31'd0, bus.done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("hi", bus.hi, e.hi);
                    check("lo", bus.lo, e.lo);
                    check("busy_cycles", busy_cnt, e.lat);
                end
            end
            if (!bus.busy) busy_cnt = 0;
        end
    end

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (bus.done) seen = 1'b1;
            else @(negedge clk);
        end
        check("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        exp_t e;
        e.hi  = exp_hi;
        e.lo  = exp_lo;
        e.lat = exp_lat(op, b);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 32'h5A5A_C3C3;
        bus.b     = 32'h0F0F_0001;
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        n_vec     = 0;
        n_err     = 0;
        busy_cnt  = 0;
        clrn      = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.cancel = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        clrn = 1'b1;

        // MTHI / MTLO while idle
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_00AA;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_0055;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check("mthi", bus.hi, 32'h0000_00AA);
        check("mtlo", bus.lo, 32'h0000_0055);

        // Directed vectors: op, a, b, expected hi, expected lo
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(2'b00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F);
        issue(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006);
        issue(2'b01, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000);
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        issue(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        issue(2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
        issue(2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
        issue(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // MTHI coinciding with start lands, MTHI while busy is dropped, FIX overwrites.
        e.hi  = 32'd0;
        e.lo  = 32'd6;
        e.lat = exp_lat(2'b01, 32'd3);
        sb.push_back(e);
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_0077;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        check("mthi_with_start", bus.hi, 32'h0000_0077);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_0099;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check("mthi_while_busy", bus.hi, 32'h0000_0077);
        wait_done();

        // Cancel at CALC edge 10 with a stray start during busy.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd100;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", {31'd0, bus.busy}, 32'd0);
        check("cancel_hi", bus.hi, 32'd0);
        check("cancel_lo", bus.lo, 32'd6);
        repeat (40) @(negedge clk);

        // Cancel overrides a simultaneous start in IDLE.
        bus.start  = 1'b1;
        bus.cancel = 1'b1;
        bus.op     = 2'b00;
        bus.a      = 32'd1;
        bus.b      = 32'd1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check("cancel_idle_busy", {31'd0, bus.busy}, 32'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of CALC.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        #2 clrn = 1'b0;
        #1;
        check("mid_rst_hi", bus.hi, 32'd0);
        check("mid_rst_lo", bus.lo, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (40) @(negedge clk);

        check("scoreboard_left", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the EXE stage of the pipelined MIPS CPU.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI and LO registers.
- Exports busy so the hazard unit stalls the pipeline on dependent MFHI/MFLO.
- Single-cycle ALU ops (ADD/SUB/AND/OR/XOR/LUI/shifts) never enter this block.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 5: iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- clrn, input, 1: asynchronous active-low reset.
- start, input, 1: issue request; sampled only in IDLE.
- op, input, 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- a, input, WIDTH: rs operand (multiplicand or dividend).
- b, input, WIDTH: rt operand (multiplier or divisor).
- cancel, input, 1: pipeline flush; aborts the operation in progress.
- hi_we, input, 1: MTHI write enable.
- lo_we, input, 1: MTLO write enable.
- wdata, input, WIDTH: MTHI/MTLO write data.
- busy, output, 1: operation in progress; high in CALC and FIX.
- done, output, 1: one-cycle pulse, high in the cycle after HI/LO are updated.
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.

Behaviour:
- Reset (clrn=0, asynchronous):
  - state = IDLE.
  - hi = 0, lo = 0, busy = 0, done = 0.
  - All internal registers cleared.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 and cancel=0 at edge E0 latches operands and moves to CALC; counter = 0.
  - For signed ops, latch |a| and |b| and record the result signs.
  - busy is registered: high in the cycle after E0.
- MULT/MULTU in CALC:
  - 2*WIDTH-bit accumulator; 2*WIDTH-bit multiplicand shifts left each edge; multiplier shifts right each edge.
  - Each edge adds the multiplicand to the accumulator if the multiplier LSB is 1.
  - Leaves CALC at the edge where counter == WIDTH-1 (edges E1..E32), then goes to FIX.
- DIV/DIVU in CALC:
  - Restoring division, one quotient bit per edge, MSB first.
  - Uses a WIDTH+1-bit partial-remainder subtract.
  - Same 32-edge count.
- Divide by zero (b == 0 at E0):
  - Skips CALC; IDLE goes directly to FIX.
  - Result: lo = all ones, hi = a (raw, unsigned view).
- FIX (one edge, E33 normally):
  - Applies sign correction and writes hi/lo, then returns to IDLE.
  - Product: negate the 64-bit value if the operand signs differ.
  - Quotient: negate if dividend and divisor signs differ.
  - Remainder: takes the dividend's sign.
  - 0x80000000 / -1 (signed) gives lo = 0x80000000, hi = 0.
- Timing:
  - done = 1 for exactly the cycle after the FIX edge.
  - busy falls in that same cycle.
  - Normal latency from the start edge to done is 33 cycles of busy.
- start while busy: ignored, no queueing.
- cancel:
  - In CALC or FIX: next edge goes to IDLE, hi/lo unchanged, no done pulse.
  - In IDLE: cancel overrides a simultaneous start.
- hi_we / lo_we:
  - Honoured only in IDLE, one edge write.
  - Ignored while busy; the pipeline stalls these.
  - A write coinciding with start in IDLE takes effect, and the later FIX overwrites it.
- Operands are read only at E0. Changes to a and b after E0 have no effect.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply leaves CALC to FIX at the first edge after which the shifted multiplier is zero.
  - MULT with a zero multiplier, or |b| == 0, goes directly to FIX.
  - Latency is variable; division is unchanged.
- Undefined: fixed 32 CALC edges for multiply.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done after 33 busy cycles; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3, b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MULDIV_EARLY_OUT_EN, a=5, b=3 gives FIX at E3, hi=0, lo=15.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 -> done one cycle after E1 (FIX at E1); lo=0xFFFFFFFF, hi=0x1234.
- Cancel at CALC edge 10 -> busy low next cycle, no done pulse, hi/lo keep their prior values. A start asserted during busy is ignored.
- Reset:
  - MTHI wdata=0xAA while idle -> hi=0xAA.
  - Drop clrn mid-CALC -> hi=lo=0, busy=0 immediately, no done.
